sm_control_unit_p: RTL
======================

Name: sm_control_unit_p

Overview:
- Parametrised next-generation control FSM for the SM core scheduler.
- Sequences fetch / execute / PC-update for one warp and drives the per-register write/increment strobes, the bus read-source select and the ALU opcode.
- Adds over the previous CU:
  - configurable fetch wait and register count
  - lane-masked all/any conditional jumps
  - start/ack handshake, abort, and a sticky illegal-instruction flag

Parameters:
- N_REGS, 12, width of write_en/inc_en; legal range 6..12
- N_LANES, 16, width of z and lane_mask
- FETCH_WAIT, 2, cycles instruction memory is read per fetch; legal range 1..15
- IW, 16, instruction width; must be at least 16

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  begin execution (sampled in IDLE)
- ack  in  1  acknowledge completion (sampled in END)
- abort  in  1  synchronous return to IDLE
- instruction  in  IW  IR contents
- z  in  N_LANES  per-lane zero flags from the lane ALUs
- lane_mask  in  N_LANES  active lanes
- alu_op  out  3  ALU opcode
- write_en  out  N_REGS  one-hot register load strobes
- inc_en  out  N_REGS  one-hot register increment strobes
- read_en  out  4  bus source: 0..N_REGS-1 = register, 12 = none, 13 = IMEM, 14 = IR immediate, 15 = AC
- busy  out  1  high in any state except IDLE
- end_process  out  1  registered completion flag
- error  out  1  sticky illegal-instruction flag

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, fetch counter=0, end_process=0, error=0
  - all other outputs 0; read_en=0
- Output style:
  - all outputs except end_process/error are Moore, decoded from state plus the IR fields
  - in any state not listed below: strobes=0, alu_op=0, read_en=0
- Instruction fields:
  - [15:12] opcode
  - [11] jump mode (0 = all, 1 = any)
  - [3:0] register index r
- Opcodes:
  - 0 NOP, 1 LOADAC, 2 STAC, 3 ADD, 4 SUB, 5 LSHIFT, 6 RSHIFT, 7 JUMP, 8 JUMPZ, 9 JUMPNZ, 15 END
  - all other opcodes are illegal
- IDLE:
  - start=1 -> FETCH with counter=0, and clear error
  - otherwise stay in IDLE
- FETCH:
  - read_en=13, write_en[IR_IDX=4]=1
  - counter increments each cycle
  - when counter==FETCH_WAIT-1 -> EXEC
- EXEC (one cycle):
  - LOADAC: read_en=r, alu_op=0 (pass), write_en[AC_IDX=5]=1 -> PCINC
  - ADD/SUB/LSHIFT/RSHIFT: read_en=r, alu_op=1/2/3/4, write_en[5]=1 -> PCINC
  - STAC: read_en=15, write_en[r]=1 -> PCINC
  - NOP: inc_en[PC_IDX=1]=1 -> FETCH
  - JUMP: read_en=14, write_en[1]=1 -> FETCH
  - JUMPZ/JUMPNZ:
    - act = z & lane_mask
    - all-cond = (act==lane_mask); any-cond = (act!=0); cond selected by mode bit
    - JUMPZ taken if cond; JUMPNZ taken if !cond
    - taken: read_en=14, write_en[1]=1
    - not taken: inc_en[1]=1
    - either way -> FETCH
  - END: read_en=12 -> END
  - illegal opcode, or r>=N_REGS on an r-using op: error<=1; treat as NOP
- PCINC: inc_en[1]=1 -> FETCH
- END:
  - read_en=12
  - end_process is registered: it goes 1 the cycle after END is entered and stays 1 while in END
  - ack=1 -> IDLE; end_process returns to 0 the cycle after leaving END
- lane_mask==0: both all-cond and any-cond evaluate false. JUMPZ is not taken and JUMPNZ is taken.
- abort=1 in any state -> IDLE next cycle; abort has priority over every other transition. error is retained.
- start is ignored outside IDLE.
- reset_n asserted mid-fetch or mid-exec: immediate IDLE; no strobe persists past the reset edge.
- Latency:
  - ALU/LOAD/STAC instruction = FETCH_WAIT+2 cycles
  - NOP/JUMP family = FETCH_WAIT+1 cycles

Decomposition:
- Package sm_cu_pkg holds:
  - opcode constants
  - ALU op codes
  - read_en source codes (12..15)
  - register indices PC_IDX=1, IR_IDX=4, AC_IDX=5
  - state enum IDLE/FETCH/EXEC/PCINC/END
- One sub-module, sm_cu_jump_eval: combinational lane-mask/all/any condition evaluator.

Test Plan:
- Reset, then start=1 with instruction=0x3002 (ADD r2), FETCH_WAIT=2 -> exact sequence:
  - 2 cycles read_en=13, write_en=0x010
  - 1 cycle read_en=2, alu_op=1, write_en=0x020
  - 1 cycle inc_en=0x002
  - then FETCH
- JUMPZ all-mode, lane_mask=0x00FF:
  - z=0x00FF -> write_en=0x002, read_en=14
  - z=0x007F -> inc_en=0x002
- JUMPNZ any-mode, lane_mask=0, z=0xFFFF -> taken (write_en=0x002).
- Opcode 0xA000 -> error=1, inc_en=0x002, continues fetching; error clears only on the next start from IDLE.
- instruction=0xF000:
  - END entered; end_process=1 one cycle later, busy=1
  - ack=1 -> IDLE next cycle; busy=0; end_process=0 the following cycle
- abort pulse during FETCH, and separately reset_n=0 during EXEC -> IDLE, all strobes 0 on the next edge (for reset: immediately).

Source files
------------

// File: rtl/sm_cu_pkg.sv
// Shared constants and types for the SM core control unit.
package sm_cu_pkg;

    // Instruction opcodes (instruction[15:12])
    localparam logic [3:0] OP_NOP    = 4'd0;
    localparam logic [3:0] OP_LOADAC = 4'd1;
    localparam logic [3:0] OP_STAC   = 4'd2;
    localparam logic [3:0] OP_ADD    = 4'd3;
    localparam logic [3:0] OP_SUB    = 4'd4;
    localparam logic [3:0] OP_LSHIFT = 4'd5;
    localparam logic [3:0] OP_RSHIFT = 4'd6;
    localparam logic [3:0] OP_JUMP   = 4'd7;
    localparam logic [3:0] OP_JUMPZ  = 4'd8;
    localparam logic [3:0] OP_JUMPNZ = 4'd9;
    localparam logic [3:0] OP_END    = 4'd15;

    // ALU opcodes
    localparam logic [2:0] ALU_PASS   = 3'd0;
    localparam logic [2:0] ALU_ADD    = 3'd1;
    localparam logic [2:0] ALU_SUB    = 3'd2;
    localparam logic [2:0] ALU_LSHIFT = 3'd3;
    localparam logic [2:0] ALU_RSHIFT = 3'd4;

    // Bus read-source codes above the register range
    localparam logic [3:0] SRC_NONE = 4'd12;
    localparam logic [3:0] SRC_IMEM = 4'd13;
    localparam logic [3:0] SRC_IMM  = 4'd14;
    localparam logic [3:0] SRC_AC   = 4'd15;

    // Architectural register indices
    localparam logic [3:0] PC_IDX = 4'd1;
    localparam logic [3:0] IR_IDX = 4'd4;
    localparam logic [3:0] AC_IDX = 4'd5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        PCINC = 3'd3,
        END   = 3'd4
    } state_t;

    // Map an arithmetic/shift opcode onto the ALU operation it requests.
    function automatic logic [2:0] alu_of(input logic [3:0] op);
        logic [2:0] res;
        res = ALU_PASS;
        case (op)
            OP_ADD:    res = ALU_ADD;
            OP_SUB:    res = ALU_SUB;
            OP_LSHIFT: res = ALU_LSHIFT;
            OP_RSHIFT: res = ALU_RSHIFT;
            default:   res = ALU_PASS;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/sm_cu_jump_eval.sv
// Lane-masked branch condition: "all active lanes zero" or "any active lane zero".
module sm_cu_jump_eval #(
    parameter int N_LANES = 16
) (
    input  logic [N_LANES-1:0] z,
    input  logic [N_LANES-1:0] lane_mask,
    input  logic               any_mode,
    output logic               cond
);

    logic [N_LANES-1:0] act;
    logic               all_c;
    logic               any_c;

    // An empty mask makes both conditions false, so JUMPNZ falls through as taken.
    always_comb begin
        act   = z & lane_mask;
        all_c = (lane_mask != '0) && (act == lane_mask);
        any_c = (act != '0);
        cond  = any_mode ? any_c : all_c;
    end

endmodule

// File: rtl/sm_control_unit_p.sv
// Warp control FSM: fetch / execute / PC-update sequencing with start/ack handshake.
module sm_control_unit_p
    import sm_cu_pkg::*;
#(
    parameter int N_REGS     = 12,
    parameter int N_LANES    = 16,
    parameter int FETCH_WAIT = 2,
    parameter int IW         = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    input  logic                ack,
    input  logic                abort,
    input  logic [IW-1:0]       instruction,
    input  logic [N_LANES-1:0]  z,
    input  logic [N_LANES-1:0]  lane_mask,
    output logic [2:0]          alu_op,
    output logic [N_REGS-1:0]   write_en,
    output logic [N_REGS-1:0]   inc_en,
    output logic [3:0]          read_en,
    output logic                busy,
    output logic                end_process,
    output logic                error
);

    localparam logic [3:0] FETCH_LAST = 4'(FETCH_WAIT - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        error_q, error_d;
    logic        end_process_q;

    logic [3:0]  op;
    logic [3:0]  r;
    logic        jump_cond;
    logic        unused_instr;

    assign op = instruction[15:12];
    assign r  = instruction[3:0];
    // Operand bits not decoded here are still part of the IR word.
    assign unused_instr = ^instruction;

    function automatic logic [N_REGS-1:0] reg_bit(input logic [3:0] idx);
        return N_REGS'(1) << idx;
    endfunction

    sm_cu_jump_eval #(
        .N_LANES (N_LANES)
    ) u_jump_eval (
        .z         (z),
        .lane_mask (lane_mask),
        .any_mode  (instruction[11]),
        .cond      (jump_cond)
    );

    // State register, fetch counter, sticky error and registered completion flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            error_q       <= 1'b0;
            end_process_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            error_q       <= error_d;
            end_process_q <= (state_q == END);
        end
    end

    // Next-state and Moore strobe decode from the current state and IR fields.
    always_comb begin
        logic r_ok;
        logic bad;
        logic taken;

        state_d  = state_q;
        cnt_d    = cnt_q;
        error_d  = error_q;
        alu_op   = ALU_PASS;
        write_en = '0;
        inc_en   = '0;
        read_en  = '0;
        r_ok     = (int'(r) < N_REGS);
        bad      = 1'b0;
        taken    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    cnt_d   = '0;
                    error_d = 1'b0;
                end
            end
            FETCH: begin
                read_en  = SRC_IMEM;
                write_en = reg_bit(IR_IDX);
                if (cnt_q == FETCH_LAST) begin
                    cnt_d   = '0;
                    state_d = EXEC;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            EXEC: begin
                case (op)
                    OP_LOADAC, OP_ADD, OP_SUB, OP_LSHIFT, OP_RSHIFT: begin
                        if (r_ok) begin
                            read_en  = r;
                            alu_op   = alu_of(op);
                            write_en = reg_bit(AC_IDX);
                            state_d  = PCINC;
                        end else begin
                            bad = 1'b1;
                        end
                    end
                    OP_STAC: begin
                        if (r_ok) begin
                            read_en  = SRC_AC;
                            write_en = reg_bit(r);
                            state_d  = PCINC;
                        end else begin
                            bad = 1'b1;
                        end
                    end
                    OP_NOP: begin
                        inc_en  = reg_bit(PC_IDX);
                        state_d = FETCH;
                    end
                    OP_JUMP: begin
                        read_en  = SRC_IMM;
                        write_en = reg_bit(PC_IDX);
                        state_d  = FETCH;
                    end
                    OP_JUMPZ, OP_JUMPNZ: begin
                        taken = (op == OP_JUMPZ) ? jump_cond : !jump_cond;
                        if (taken) begin
                            read_en  = SRC_IMM;
                            write_en = reg_bit(PC_IDX);
                        end else begin
                            inc_en = reg_bit(PC_IDX);
                        end
                        state_d = FETCH;
                    end
                    OP_END: begin
                        read_en = SRC_NONE;
                        state_d = END;
                    end
                    default: bad = 1'b1;
                endcase
                // Illegal encodings flag an error and fall through like a NOP.
                if (bad) begin
                    error_d = 1'b1;
                    inc_en  = reg_bit(PC_IDX);
                    state_d = FETCH;
                end
            end
            PCINC: begin
                inc_en  = reg_bit(PC_IDX);
                state_d = FETCH;
            end
            END: begin
                read_en = SRC_NONE;
                if (ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort overrides every other transition but leaves the error flag as it was.
        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
            error_d = error_q;
        end
    end

    assign busy        = (state_q != IDLE);
    assign end_process = end_process_q;
    assign error       = error_q;

endmodule
